// File: rtl/uart_cmd_encoder.sv
// Serialises one ALU command into the six-byte frame 0x08,A,0x10,B,0x20,op
// and paces it through a UART transmitter, one byte per i_txDone handshake.
module uart_cmd_encoder #(
    parameter int NB_DATA    = 8,
    parameter int NB_OP      = 6,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_DATA-1:0] i_datoA,
    input  logic [NB_DATA-1:0] i_datoB,
    input  logic [NB_OP-1:0]   i_operation,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_data,
    input  logic               i_txDone,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [NB_DATA-1:0] TAG_A  = NB_DATA'(6'b001000);
    localparam logic [NB_DATA-1:0] TAG_B  = NB_DATA'(6'b010000);
    localparam logic [NB_DATA-1:0] TAG_OP = NB_DATA'(6'b100000);

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic               start_q, start_d, ready_q, ready_d;
    logic               busy_q, busy_d, done_q, done_d;

    function automatic logic [NB_DATA-1:0] frame_byte(
        input logic [2:0]         idx,
        input logic [NB_DATA-1:0] a,
        input logic [NB_DATA-1:0] b,
        input logic [NB_OP-1:0]   op
    );
        case (idx)
            3'd0:    frame_byte = TAG_A;
            3'd1:    frame_byte = a;
            3'd2:    frame_byte = TAG_B;
            3'd3:    frame_byte = b;
            3'd4:    frame_byte = TAG_OP;
            default: frame_byte = NB_DATA'(op);
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = i_datoA;
                    b_d     = i_datoB;
                    op_d    = i_operation;
                    idx_d   = 3'd0;
                    data_d  = TAG_A;
                    state_d = SEND;
                end
            end
            SEND: state_d = WAIT;
            WAIT: begin
                if (i_txDone) begin
                    if (idx_q == 3'd5) begin
                        idx_d   = 3'd0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        if (GAP_CYCLES == 0) begin
                            data_d  = frame_byte(idx_q + 3'd1, a_q, b_q, op_q);
                            state_d = SEND;
                        end else begin
                            gap_d   = '0;
                            state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                // Next byte is loaded as SEND is entered, so o_data stays put across the gap
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    data_d  = frame_byte(idx_q, a_q, b_q, op_q);
                    state_d = SEND;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        start_d = (state_d == SEND);
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            data_q  <= '0;
            start_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            data_q  <= data_d;
            start_q <= start_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_tx_start = start_q;
    assign o_data     = data_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_uart_cmd_encoder.sv
// Directed bench: a GAP_CYCLES=2 encoder and a GAP_CYCLES=0 encoder, each driven by a
// UART model that answers every tx_start with txDone ten cycles later.
module tb_uart_cmd_encoder;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] vld;
    logic [7:0] a, b;
    logic [5:0] op;
    logic [1:0] rdy, txs, busy, dn, mdone;
    logic [7:0] dat0, dat1;
    logic       spur;
    logic       txd0, txd1;

    assign txd0 = mdone[0] | spur;
    assign txd1 = mdone[1];

    uart_cmd_encoder #(.NB_DATA(8), .NB_OP(6), .GAP_CYCLES(2)) dut0 (
        .clk(clk), .i_rst(rst), .i_valid(vld[0]), .o_ready(rdy[0]),
        .i_datoA(a), .i_datoB(b), .i_operation(op),
        .o_tx_start(txs[0]), .o_data(dat0), .i_txDone(txd0),
        .o_busy(busy[0]), .o_done(dn[0])
    );

    uart_cmd_encoder #(.NB_DATA(8), .NB_OP(6), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .i_rst(rst), .i_valid(vld[1]), .o_ready(rdy[1]),
        .i_datoA(a), .i_datoB(b), .i_operation(op),
        .o_tx_start(txs[1]), .o_data(dat1), .i_txDone(txd1),
        .o_busy(busy[1]), .o_done(dn[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // UART model and output monitor, both sampling mid-cycle
    int         cnt   [2];
    int         nst   [2];
    int         ndone [2];
    int         dcyc  [2];
    logic [7:0] bq    [2][64];
    int         scyc  [2][64];

    initial begin
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0; nst[k] = 0; ndone[k] = 0; dcyc[k] = 0;
        end
        mdone = 2'b00;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                cnt[k]   <= 0;
                mdone[k] <= 1'b0;
            end else begin
                mdone[k] <= (cnt[k] == 1);
                cnt[k]   <= txs[k] ? 10 : ((cnt[k] > 0) ? cnt[k] - 1 : 0);
            end
            if (txs[k]) begin
                bq[k][nst[k]]   <= (k == 0) ? dat0 : dat1;
                scyc[k][nst[k]] <= cyc;
                nst[k]          <= nst[k] + 1;
            end
            if (dn[k]) begin
                ndone[k] <= ndone[k] + 1;
                dcyc[k]  <= cyc;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int k, input int target, input int budget);
        int n;
        n = 0;
        while (ndone[k] < target && n < budget) begin
            tick();
            n++;
        end
        if (ndone[k] < target) chk($sformatf("timeout_done%0d_%0d", k, target), 0, 1);
    endtask

    task automatic wait_start(input int k, input int target, input int budget);
        int n;
        n = 0;
        while (nst[k] < target && n < budget) begin
            tick();
            n++;
        end
        if (nst[k] < target) chk($sformatf("timeout_start%0d_%0d", k, target), 0, 1);
    endtask

    task automatic wait_cyc(input int target, input int budget);
        int n;
        n = 0;
        while (cyc < target && n < budget) begin
            tick();
            n++;
        end
        if (cyc != target) chk("timeout_cyc", cyc, target);
    endtask

    task automatic chk_frame(input string tag, input int k, input int base, input int nb,
                             input logic [47:0] exp);
        for (int i = 0; i < nb; i++)
            chk($sformatf("%s_b%0d", tag, i), bq[k][base+i], exp[47-8*i -: 8]);
    endtask

    task automatic chk_spacing(input string tag, input int k, input int base, input int gap);
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s_sp%0d", tag, i), scyc[k][base+i+1] - scyc[k][base+i], gap);
    endtask

    int acc, acc2, acc4;

    initial begin
        rst  = 1'b1;
        vld  = 2'b00;
        a    = 8'h00;
        b    = 8'h00;
        op   = 6'h00;
        spur = 1'b0;
        repeat (3) tick();
        chk("rst_ready", rdy[0], 1);
        chk("rst_start", txs[0], 0);
        chk("rst_data",  dat0, 0);
        chk("rst_busy",  busy[0], 0);
        chk("rst_done",  dn[0], 0);
        chk("rst_ready1", rdy[1], 1);

        // Request presented for the very first edge after reset release
        @(negedge clk);
        rst = 1'b0;
        vld = 2'b11;
        a = 8'h05; b = 8'h03; op = 6'h20;
        acc = cyc;
        @(negedge clk);
        vld = 2'b01;
        a = 8'hFF; b = 8'h80; op = 6'h3F;
        #1;
        chk("busy_ready_low", rdy[0], 0);
        chk("busy_high", busy[0], 1);
        chk("first_start_cyc", scyc[0][0], acc + 1);
        chk("first_start_data", bq[0][0], 8'h08);

        wait_done(0, 1, 300);
        chk("done_ready", rdy[0], 1);
        chk("done_lat", dcyc[0], scyc[0][5] + 11);
        chk("f1_nstart", nst[0], 6);
        chk_frame("f1", 0, 0, 6, 48'h08_05_10_03_20_20);
        chk_spacing("f1", 0, 0, 13);
        acc2 = cyc;

        // Held request accepted in the done cycle; now in SEND of frame 2
        @(negedge clk);
        vld = 2'b00;
        #1;
        chk("b2b_start_cyc", scyc[0][6], acc2 + 1);
        chk("b2b_start_data", bq[0][6], 8'h08);
        spur = 1'b1;
        tick();
        spur = 1'b0;
        wait_cyc(scyc[0][6] + 11, 40);
        spur = 1'b1;
        tick();
        spur = 1'b0;
        wait_done(0, 2, 300);
        chk("f2_nstart", nst[0], 12);
        chk_frame("f2", 0, 6, 6, 48'h08_FF_10_80_20_3F);
        chk_spacing("f2", 0, 6, 13);

        chk("g0_ndone", ndone[1], 1);
        chk("g0_nstart", nst[1], 6);
        chk_frame("g0", 1, 0, 6, 48'h08_05_10_03_20_20);
        chk_spacing("g0", 1, 0, 11);

        // Frame 3 is aborted by an asynchronous reset while byte 3 is in flight
        tick();
        @(negedge clk);
        vld = 2'b01;
        a = 8'h11; b = 8'h22; op = 6'h05;
        @(negedge clk);
        vld = 2'b00;
        #1;
        wait_start(0, 16, 300);
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy",  busy[0], 0);
        chk("arst_ready", rdy[0], 1);
        chk("arst_data",  dat0, 0);
        chk("arst_start", txs[0], 0);
        chk("arst_done",  dn[0], 0);
        chk_frame("f3", 0, 12, 4, 48'h08_11_10_22_00_00);
        repeat (3) tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        repeat (20) tick();
        chk("post_rst_nstart", nst[0], 16);
        chk("post_rst_ndone", ndone[0], 2);

        @(negedge clk);
        vld = 2'b01;
        a = 8'h5A; b = 8'hA5; op = 6'h01;
        acc4 = cyc;
        @(negedge clk);
        vld = 2'b00;
        #1;
        chk("f4_start_cyc", scyc[0][16], acc4 + 1);
        wait_done(0, 3, 300);
        chk("f4_ndone", ndone[0], 3);
        chk("f4_nstart", nst[0], 22);
        chk_frame("f4", 0, 16, 6, 48'h08_5A_10_A5_20_01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
